bfp_block_exp_align: RTL

//  Sequential block-floating-point exponent aligner for the FFT pipeline. Collects a block of

---
 rtl/bfp_pkg.sv | 36 +++
 rtl/bfp_block_exp_align_max_tree.sv | 34 +++
 rtl/bfp_block_exp_align.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point exponent aligner.
package bfp_pkg;

  localparam int EXP_W_DEF = 4;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Result of one lane's alignment: clip flag plus saturated shift amount.
  typedef struct packed {
    logic        clip;
    logic [15:0] shift;
  } shift_res_t;

  // Saturated right-shift amount for one lane. Operands are zero-extended to
  // 16 bits, so an exponent above the block maximum is detected by magnitude
  // compare rather than by the sign of a narrow subtraction.
  function automatic shift_res_t sat_shift(input logic [15:0] blk_max,
                                           input logic [15:0] exp_val,
                                           input logic [15:0] max_shift);
    shift_res_t  res;
    logic [15:0] d;
    res = '0;
    if (exp_val > blk_max) begin
      res.clip  = 1'b1;
      res.shift = '0;
    end else begin
      d         = blk_max - exp_val;
      res.shift = (d > max_shift) ? max_shift : d;
    end
    return res;
  endfunction

endpackage

// File: rtl/bfp_block_exp_align_max_tree.sv
// Combinational unsigned maximum across LANES packed exponents.
// Lanes are padded with zeros up to a power of two and reduced pairwise,
// one tree level per pass, giving log2(LANES) comparator depth.
module exp_max_tree
  import bfp_pkg::*;
#(
  parameter int LANES = 8,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic [LANES*EXP_W-1:0] exp_vec,
  output logic [EXP_W-1:0]       max_out
);

  localparam int NP = 1 << $clog2(LANES);

  logic [EXP_W-1:0] lvl [NP];

  // Pairwise reduction tree; each level overwrites the lower half in place.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      lvl[i] = '0;
    end
    for (int i = 0; i < LANES; i++) begin
      lvl[i] = exp_vec[i*EXP_W +: EXP_W];
    end
    for (int w = NP / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        lvl[i] = (lvl[2*i] > lvl[2*i+1]) ? lvl[2*i] : lvl[2*i+1];
      end
    end
    max_out = lvl[0];
  end

endmodule

// File: rtl/bfp_block_exp_align.sv
// Block exponent aligner: buffers one block of DEPTH beats while tracking the
// block maximum, then replays it with per-lane saturated shift amounts.
//
// state | meaning
// ------+--------------------------------------------------------------
// FILL  | accepting input beats into the buffer, tracking running max
// DRAIN | presenting buffered beats with shift amounts, input stalled
module bfp_block_exp_align
  import bfp_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int EXP_W     = EXP_W_DEF,
  parameter int DEPTH     = 4,
  parameter int MAX_SHIFT = (2 ** EXP_W) - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*EXP_W-1:0] in_exp,
  input  logic                   in_last,
  input  logic                   ext_en,
  input  logic [EXP_W-1:0]       ext_max,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*EXP_W-1:0] out_shift,
  output logic [EXP_W-1:0]       out_max,
  output logic [LANES-1:0]       out_clip,
  output logic                   out_last,
  output logic                   err_len
);

  localparam int            CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [EXP_W-1:0]       run_max;
  logic [EXP_W-1:0]       blk_max;
  logic [LANES*EXP_W-1:0] buf_mem [DEPTH];

  logic                   in_acc;
  logic                   out_acc;
  logic                   cnt_last;
  logic [EXP_W-1:0]       beat_max;
  logic [EXP_W-1:0]       run_beat_max;
  logic [EXP_W-1:0]       blk_max_nxt;
  logic [CW-1:0]          rd_idx;
  logic [EXP_W-1:0]       src_max;
  logic [LANES*EXP_W-1:0] src_vec;
  logic [LANES*EXP_W-1:0] shift_nxt;
  logic [LANES-1:0]       clip_nxt;

  assign in_ready = (state == FILL);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid && out_ready;
  assign cnt_last = (cnt == LAST_IDX);

  exp_max_tree #(
    .LANES (LANES),
    .EXP_W (EXP_W)
  ) u_max_tree (
    .exp_vec (in_exp),
    .max_out (beat_max)
  );

  // Block maximum candidate including the beat currently on the input.
  always_comb begin
    run_beat_max = (run_max > beat_max) ? run_max : beat_max;
    blk_max_nxt  = ext_en ? ext_max : run_beat_max;
  end

  // Select the beat to be presented next. In FILL this is beat 0 of the block
  // just closing (taken straight from the input when the block is one beat);
  // in DRAIN it is the beat after the one currently presented.
  always_comb begin
    rd_idx = cnt_last ? '0 : cnt + CW'(1);
    if (state == FILL) begin
      src_max = blk_max_nxt;
      src_vec = (DEPTH == 1) ? in_exp : buf_mem[0];
    end else begin
      src_max = blk_max;
      src_vec = buf_mem[rd_idx];
    end
  end

  // Per-lane shift and clip for the selected beat.
  always_comb begin
    shift_res_t res;
    shift_nxt = '0;
    clip_nxt  = '0;
    for (int i = 0; i < LANES; i++) begin
      res = sat_shift(16'(src_max), 16'(src_vec[i*EXP_W +: EXP_W]), 16'(MAX_SHIFT));
      clip_nxt[i]                  = res.clip;
      shift_nxt[i*EXP_W +: EXP_W] = res.shift[EXP_W-1:0];
    end
  end

  // Block buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (in_acc) begin
      buf_mem[cnt] <= in_exp;
    end
  end

  // FILL/DRAIN sequencer with registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      run_max   <= '0;
      blk_max   <= '0;
      out_valid <= 1'b0;
      out_shift <= '0;
      out_max   <= '0;
      out_clip  <= '0;
      out_last  <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_acc) begin
            if (in_last != cnt_last) begin
              err_len <= 1'b1;
            end
            if (cnt_last) begin
              blk_max   <= blk_max_nxt;
              run_max   <= '0;
              cnt       <= '0;
              state     <= DRAIN;
              out_valid <= 1'b1;
              out_shift <= shift_nxt;
              out_clip  <= clip_nxt;
              out_max   <= blk_max_nxt;
              out_last  <= (DEPTH == 1);
            end else begin
              run_max <= run_beat_max;
              cnt     <= cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_acc) begin
            if (cnt_last) begin
              state     <= FILL;
              cnt       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              cnt       <= cnt + CW'(1);
              out_shift <= shift_nxt;
              out_clip  <= clip_nxt;
              out_last  <= (rd_idx == LAST_IDX);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule
